obi_rvalid_stall: RTL and testbench
===================================

Name: obi_rvalid_stall

Overview:
- Downstream companion to the OBI grant-stall stage in the testbench memory path.
- Captures memory responses (rvalid, rdata, err) for granted transactions and buffers them in an in-order FIFO.
- Releases each response to the core after a programmable number of stall cycles.
- Tracks outstanding transactions and exports a grant-permit signal, so the upstream grant stage never over-subscribes the response buffer.

Parameters:
DEPTH, 4, response FIFO depth and maximum outstanding transactions (power of 2, >=2)
DATA_WIDTH, 32, rdata width
MAX_STALL_N, 15, saturation limit for a per-response stall value

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_core_i  in  1  core OBI request
gnt_core_i  in  1  grant seen by core (from grant-stall stage)
gnt_permit_o  out  1  high when outstanding < DEPTH; upstream ANDs into grant
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_WIDTH  memory read data
mem_err_i  in  1  memory response error
rvalid_core_o  out  1  response valid to core, one cycle per response
rdata_core_o  out  DATA_WIDTH  response data to core
err_core_o  out  1  response error to core
en_stall_i  in  1  0 forces all stall values to 0
rvalid_stall_i  in  32  stall cycles applied to the response captured this cycle
outstanding_o  out  $clog2(DEPTH)+1  current outstanding count
overflow_o  out  1  sticky: response arrived with FIFO full and no pop

Behaviour:
Reset (asynchronous, rst_ni low):
- FIFO empty, read/write pointers 0, head counter 0, outstanding 0.
- rvalid_core_o=0, rdata_core_o=0, err_core_o=0, overflow_o=0, gnt_permit_o=1.

Outstanding counter:
- +1 on a cycle with req_core_i & gnt_core_i.
- -1 on a cycle with rvalid_core_o.
- Both in the same cycle: unchanged.
- Never wraps. Decrement at 0 is ignored.
- gnt_permit_o = (outstanding < DEPTH), decoded from the register only (no combinational path from inputs).

Capture:
- On mem_rvalid_i, push {rdata, err, stall} into the FIFO.
- stall = en_stall_i ? min(rvalid_stall_i, MAX_STALL_N) : 0. Width is $clog2(MAX_STALL_N+1); the value saturates and never truncates.

Head FSM, states EMPTY, COUNT, RELEASE:
- EMPTY -> COUNT when a push occurs. The head counter loads the pushed stall value.
- COUNT: the counter decrements each cycle. When it reaches 0, go to RELEASE.
- Entry with stall 0 goes directly to RELEASE.
- RELEASE: rvalid_core_o=1 for exactly one cycle; rdata_core_o and err_core_o come from the head entry. Pop the head.
- After RELEASE: if the FIFO is non-empty, load the next entry's stall into the counter and go to COUNT (or RELEASE again if that stall is 0). Otherwise go to EMPTY.
- rdata_core_o holds its last value when rvalid_core_o=0.

Latency and ordering:
- Response captured at edge k with stall d on an empty FIFO: rvalid_core_o is high in the cycle after edge k+1+d.
- Stall 0 gives one cycle of registered latency.
- Later entries start counting only once they become head, so stalls accumulate serially.
- Back-to-back stall-0 responses give one rvalid per cycle.
- Responses are strictly in order. There is no core-side backpressure (OBI rvalid has no ready).

Boundaries:
- Push and pop in the same cycle is legal at any occupancy, including full.
- Push while full with no pop: the entry is dropped and overflow_o sets, staying set until reset.
- mem_rvalid_i while outstanding=0 is still captured. It does not affect the outstanding counter below 0.
- Reset asserted mid-stall discards all entries and counters immediately. No rvalid_core_o is produced for the discarded entries.
- Pointer wrap uses DEPTH modulo arithmetic with an extra bit for full/empty.

Test Plan:
- Reset, then single read: mem_rvalid_i at edge 10, rdata=0xDEADBEEF, stall 0 -> rvalid_core_o high exactly in the cycle after edge 11, rdata_core_o=0xDEADBEEF, err_core_o=0.
- Stall 3, en_stall_i=1: capture at edge 20 -> rvalid_core_o after edge 24. Same stimulus with en_stall_i=0 -> rvalid_core_o after edge 21.
- Saturation: rvalid_stall_i=100, MAX_STALL_N=15 -> rvalid_core_o 16 cycles after capture.
- Four back-to-back responses with stalls 2,0,1,0: outputs in order A,B,C,D at capture+3, +4, +6, +7. gnt_permit_o low while outstanding=4.
- Full FIFO (4 entries, head stalled): a 5th mem_rvalid_i with no pop -> overflow_o=1 and stays set. A push coinciding with a pop -> accepted, overflow_o unchanged.
- rst_ni pulsed low mid-count with 2 entries queued -> all outputs 0 immediately, no later rvalid_core_o, outstanding_o=0, gnt_permit_o=1.

Source files
------------

// File: rtl/obi_rvalid_stall.sv
// Response-side stall stage for the OBI testbench memory path: buffers memory
// responses in order and releases each to the core after its own stall count.
module obi_rvalid_stall #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_STALL_N = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_core_i,
  input  logic                       gnt_core_i,
  output logic                       gnt_permit_o,
  input  logic                       mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i,
  input  logic                       mem_err_i,
  output logic                       rvalid_core_o,
  output logic [DATA_WIDTH-1:0]      rdata_core_o,
  output logic                       err_core_o,
  input  logic                       en_stall_i,
  input  logic [31:0]                rvalid_stall_i,
  output logic [$clog2(DEPTH):0]     outstanding_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(MAX_STALL_N + 1);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_COUNT,
    S_RELEASE
  } state_e;

  // Handshakes: neither mem_rvalid_i nor rvalid_core_o has a ready; every
  // cycle with valid high is one completed transfer, accepted unconditionally.

  state_e                state_q, state_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] data_mem  [DEPTH];
  logic                  err_mem   [DEPTH];
  logic [SW-1:0]         stall_mem [DEPTH];

  logic [SW-1:0] stall_in;
  logic [AW:0]   rd_next;
  logic          fifo_empty, fifo_full, more_after_pop;
  logic          push, pop;
  logic [SW-1:0] head_stall, next_stall;

  always_comb begin
    stall_in = '0;
    if (en_stall_i) begin
      if (rvalid_stall_i > 32'(MAX_STALL_N)) stall_in = SW'(MAX_STALL_N);
      else                                   stall_in = rvalid_stall_i[SW-1:0];
    end
  end

  assign rd_next        = rd_ptr_q + ONE_C;
  assign fifo_empty     = (wr_ptr_q == rd_ptr_q);
  assign fifo_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign more_after_pop = (rd_next != wr_ptr_q);
  assign head_stall     = stall_mem[rd_ptr_q[AW-1:0]];
  assign next_stall     = stall_mem[rd_next[AW-1:0]];

  // A push while full is accepted only when the head slot frees up this cycle.
  assign push       = mem_rvalid_i && (!fifo_full || pop);
  assign overflow_d = overflow_q || (mem_rvalid_i && fifo_full && !pop);
  assign wr_ptr_d   = push ? (wr_ptr_q + ONE_C) : wr_ptr_q;
  assign rd_ptr_d   = pop  ? rd_next            : rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q[AW-1:0]]  <= mem_rdata_i;
      err_mem[wr_ptr_q[AW-1:0]]   <= mem_err_i;
      stall_mem[wr_ptr_q[AW-1:0]] <= stall_in;
    end
  end

  // Head FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Head FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_EMPTY: begin
        if (!fifo_empty) begin
          cnt_d   = head_stall;
          state_d = (head_stall == '0) ? S_RELEASE : S_COUNT;
        end
      end
      S_COUNT: begin
        if (cnt_q <= SW'(1)) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q - SW'(1);
        end
      end
      S_RELEASE: begin
        if (more_after_pop) begin
          cnt_d   = next_stall;
          state_d = (next_stall == '0) ? S_RELEASE : S_COUNT;
        end else begin
          cnt_d   = '0;
          state_d = S_EMPTY;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_EMPTY;
      end
    endcase
  end

  // Head FSM: outputs
  always_comb begin
    rvalid_core_o = 1'b0;
    pop           = 1'b0;
    if (state_q == S_RELEASE) begin
      rvalid_core_o = 1'b1;
      pop           = 1'b1;
    end
  end

  assign rdata_d      = pop ? data_mem[rd_ptr_q[AW-1:0]] : rdata_q;
  assign err_d        = pop ? err_mem[rd_ptr_q[AW-1:0]]  : err_q;
  // Live head data during release, last released value otherwise.
  assign rdata_core_o = pop ? data_mem[rd_ptr_q[AW-1:0]] : rdata_q;
  assign err_core_o   = pop ? err_mem[rd_ptr_q[AW-1:0]]  : err_q;

  always_comb begin
    outst_d = outst_q;
    if ((req_core_i && gnt_core_i) && !rvalid_core_o) begin
      if (outst_q != DEPTH_C) outst_d = outst_q + ONE_C;
    end else if (rvalid_core_o && !(req_core_i && gnt_core_i)) begin
      if (outst_q != '0) outst_d = outst_q - ONE_C;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      outst_q    <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      outst_q    <= outst_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign outstanding_o = outst_q;
  assign gnt_permit_o  = (outst_q < DEPTH_C);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_obi_rvalid_stall.sv
// Directed bench for obi_rvalid_stall: vector table for single-response latency
// and saturation, hand-written sequences for ordering, full/overflow and reset.
module tb_obi_rvalid_stall;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_core_i, gnt_core_i, gnt_permit_o;
  logic          mem_rvalid_i, mem_err_i;
  logic [DW-1:0] mem_rdata_i;
  logic          rvalid_core_o, err_core_o;
  logic [DW-1:0] rdata_core_o;
  logic          en_stall_i;
  logic [31:0]   rvalid_stall_i;
  logic [2:0]    outstanding_o;
  logic          overflow_o;

  obi_rvalid_stall #(.DEPTH(4), .DATA_WIDTH(DW), .MAX_STALL_N(15)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_core_i     (req_core_i),
    .gnt_core_i     (gnt_core_i),
    .gnt_permit_o   (gnt_permit_o),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .rvalid_core_o  (rvalid_core_o),
    .rdata_core_o   (rdata_core_o),
    .err_core_o     (err_core_o),
    .en_stall_i     (en_stall_i),
    .rvalid_stall_i (rvalid_stall_i),
    .outstanding_o  (outstanding_o),
    .overflow_o     (overflow_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Scoreboard
  logic [DW:0] exp_q[$];
  int          exp_cyc_q[$];
  int          n_tot = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          rv_cnt = 0;

  typedef struct {
    logic [31:0] stall;
    logic        en;
    logic [31:0] data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock; samples 1ns after the edge and scores any released response.
  task automatic step();
    logic [DW:0] e;
    int          t;
    @(posedge clk_i);
    #1;
    cyc++;
    if (rvalid_core_o === 1'b1) begin
      rv_cnt++;
      if (exp_q.size() == 0) begin
        n_tot++;
        n_bad++;
        $display("FAIL unexpected_rvalid got data=%0h exp none (cyc %0d)", rdata_core_o, cyc);
      end else begin
        e = exp_q.pop_front();
        t = exp_cyc_q.pop_front();
        chk("rsp_err_data", {31'b0, err_core_o, rdata_core_o}, {31'b0, e});
        chk("rsp_cycle", 64'(cyc), 64'(t));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic grant(input int n);
    req_core_i = 1'b1;
    gnt_core_i = 1'b1;
    idle(n);
    req_core_i = 1'b0;
    gnt_core_i = 1'b0;
  endtask

  // Capture one response at the next edge; exp_cyc < 0 means no release expected.
  task automatic cap(input logic [31:0] data, input logic err, input logic [31:0] stall,
                     input logic en, input int exp_cyc);
    mem_rvalid_i   = 1'b1;
    mem_rdata_i    = data;
    mem_err_i      = err;
    rvalid_stall_i = stall;
    en_stall_i     = en;
    if (exp_cyc >= 0) begin
      exp_q.push_back({err, data});
      exp_cyc_q.push_back(exp_cyc);
    end
    step();
    mem_rvalid_i   = 1'b0;
    mem_rdata_i    = '0;
    mem_err_i      = 1'b0;
    rvalid_stall_i = '0;
  endtask

  task automatic chk_drained(input string name);
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  initial begin
    int base;
    int rv_before;

    vecs[0] = '{32'd0,          1'b1, 32'hDEADBEEF, 1'b0, 1};
    vecs[1] = '{32'd3,          1'b1, 32'h12345678, 1'b0, 4};
    vecs[2] = '{32'd3,          1'b0, 32'hCAFEF00D, 1'b0, 1};
    vecs[3] = '{32'd100,        1'b1, 32'hA5A5A5A5, 1'b1, 16};
    vecs[4] = '{32'd15,         1'b1, 32'h0F0F0F0F, 1'b0, 16};
    vecs[5] = '{32'd14,         1'b1, 32'h11111111, 1'b1, 15};
    vecs[6] = '{32'd16,         1'b1, 32'h22222222, 1'b0, 16};
    vecs[7] = '{32'hFFFFFFFF,   1'b1, 32'h33333333, 1'b0, 16};
    vecs[8] = '{32'd1,          1'b1, 32'h44444444, 1'b1, 2};
    vecs[9] = '{32'd100,        1'b0, 32'h55555555, 1'b0, 1};

    rst_ni = 1'b0;
    req_core_i = 1'b0; gnt_core_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    en_stall_i = 1'b1; rvalid_stall_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rvalid", 64'(rvalid_core_o), 64'd0);
    chk("rst_rdata", 64'(rdata_core_o), 64'd0);
    chk("rst_err", 64'(err_core_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_permit", 64'(gnt_permit_o), 64'd1);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    rst_ni = 1'b1;
    idle(3);

    // Single-response latency and stall saturation
    for (int v = 0; v < 10; v++) begin
      grant(1);
      chk("vec_outst_up", 64'(outstanding_o), 64'd1);
      base = cyc + 1;
      cap(vecs[v].data, vecs[v].err, vecs[v].stall, vecs[v].en, base + vecs[v].lat);
      idle(20);
      chk_drained("vec_drained");
      chk("vec_rdata_hold", 64'(rdata_core_o), 64'(vecs[v].data));
      chk("vec_err_hold", 64'(err_core_o), 64'(vecs[v].err));
      chk("vec_outst_down", 64'(outstanding_o), 64'd0);
    end

    // Four back-to-back, stalls 2,0,1,0, with outstanding at its limit
    en_stall_i = 1'b1;
    grant(4);
    chk("b2b_outst_full", 64'(outstanding_o), 64'd4);
    chk("b2b_permit_low", 64'(gnt_permit_o), 64'd0);
    grant(1);
    chk("b2b_outst_sat", 64'(outstanding_o), 64'd4);
    base = cyc + 1;
    cap(32'hAAAA0001, 1'b0, 32'd2, 1'b1, base + 3);
    cap(32'hBBBB0002, 1'b1, 32'd0, 1'b1, base + 4);
    cap(32'hCCCC0003, 1'b0, 32'd1, 1'b1, base + 6);
    cap(32'hDDDD0004, 1'b0, 32'd0, 1'b1, base + 7);
    idle(10);
    chk_drained("b2b_drained");
    chk("b2b_outst_zero", 64'(outstanding_o), 64'd0);
    chk("b2b_permit_high", 64'(gnt_permit_o), 64'd1);

    // Full FIFO with head stalled; push coinciding with the first pop
    base = cyc + 1;
    cap(32'h10000001, 1'b0, 32'd15, 1'b1, base + 16);
    cap(32'h10000002, 1'b0, 32'd0,  1'b1, base + 17);
    cap(32'h10000003, 1'b1, 32'd0,  1'b1, base + 18);
    cap(32'h10000004, 1'b0, 32'd0,  1'b1, base + 19);
    idle(base + 16 - cyc);
    chk("full_no_ovf", 64'(overflow_o), 64'd0);
    cap(32'h10000005, 1'b0, 32'd0, 1'b1, base + 20);
    chk("pushpop_no_ovf", 64'(overflow_o), 64'd0);
    idle(8);
    chk_drained("pushpop_drained");
    chk("stray_rvalid_outst", 64'(outstanding_o), 64'd0);

    // Overflow: fifth response while full and no pop is dropped
    base = cyc + 1;
    cap(32'h20000001, 1'b0, 32'd15, 1'b1, base + 16);
    cap(32'h20000002, 1'b0, 32'd0,  1'b1, base + 17);
    cap(32'h20000003, 1'b0, 32'd0,  1'b1, base + 18);
    cap(32'h20000004, 1'b0, 32'd0,  1'b1, base + 19);
    cap(32'h2000DEAD, 1'b1, 32'd0,  1'b1, -1);
    chk("ovf_set", 64'(overflow_o), 64'd1);
    idle(22);
    chk_drained("ovf_drained");
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // Reset mid-count with two entries queued
    grant(2);
    cap(32'h30000001, 1'b0, 32'd10, 1'b1, -1);
    cap(32'h30000002, 1'b0, 32'd10, 1'b1, -1);
    idle(3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(rvalid_core_o), 64'd0);
    chk("mid_rst_rdata", 64'(rdata_core_o), 64'd0);
    chk("mid_rst_outst", 64'(outstanding_o), 64'd0);
    chk("mid_rst_permit", 64'(gnt_permit_o), 64'd1);
    chk("mid_rst_ovf", 64'(overflow_o), 64'd0);
    step();
    rst_ni = 1'b1;
    rv_before = rv_cnt;
    idle(30);
    chk("post_rst_no_rvalid", 64'(rv_cnt - rv_before), 64'd0);

    // Fresh single read after reset
    base = cyc + 1;
    cap(32'hDEADBEEF, 1'b0, 32'd0, 1'b1, base + 1);
    idle(4);
    chk_drained("post_rst_read");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
